uart_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter that implements the stdout/serial-out path of the SoC. It consumes bytes written by the core's peripheral bus stage through a valid/ready write port and queues them in a small FIFO. It serialises them onto the line that drives the board's FTDI RX pin. The block decouples core writes from the baud rate, so short bursts of printf output do not stall the core.

---
 rtl/uart_tx_fifo_if.sv | 19 +
 rtl/uart_tx_fifo.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte write port of the buffered UART transmitter: valid/ready handshake
// between the core's peripheral bus stage (master) and the transmitter (slave).
interface uart_tx_fifo_if;
    logic [7:0] wdata_i;
    logic       wvalid_i;
    logic       wready_o;

    modport master (
        output wdata_i,
        output wvalid_i,
        input  wready_o
    );

    modport slave (
        input  wdata_i,
        input  wvalid_i,
        output wready_o
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small FIFO decouples core writes from the
// baud rate, and a four-state FSM serialises bytes LSB first with no idle gap.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUDRATE   = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    uart_tx_fifo_if.slave                 wr,
    output logic                          ser_tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int BW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   PTR_ONE   = {{AW{1'b0}}, 1'b1};

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_fifo: CLK_FREQ / BAUDRATE must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [7:0]     r_mem [FIFO_DEPTH];
    logic [AW:0]    r_wptr;
    logic [AW:0]    r_rptr;
    logic [7:0]     r_shift;
    logic [BW-1:0]  r_baud;
    logic [2:0]     r_bit_idx;
    logic           r_tx;
    logic           r_busy;

    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic           w_tx;
    logic           w_baud_done;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_push      = wr.wvalid_i && !w_full;
    assign w_baud_done = (r_baud == BAUD_LAST);

    assign wr.wready_o = !w_full;
    assign level_o     = r_wptr - r_rptr;
    assign ser_tx_o    = r_tx;
    assign busy_o      = r_busy;

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state, FIFO pop request and line level for the current state
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_tx         = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_tx = 1'b1;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = S_START;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_START: begin
                w_tx = 1'b0;
                if (w_baud_done) begin
                    w_next_state = S_DATA;
                end else begin
                    w_next_state = S_START;
                end
            end
            S_DATA: begin
                w_tx = r_shift[0];
                if (w_baud_done && (r_bit_idx == 3'd7)) begin
                    w_next_state = S_STOP;
                end else begin
                    w_next_state = S_DATA;
                end
            end
            S_STOP: begin
                w_tx = 1'b1;
                if (w_baud_done) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_next_state = S_START;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else begin
                    w_next_state = S_STOP;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // FIFO storage, written only on an accepted handshake
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= wr.wdata_i;
        end
    end

    // FIFO pointers; reset discards any queued bytes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    // Shift register, baud and bit counters, registered line and busy flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_shift   <= 8'h00;
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_tx   <= w_tx;
            r_busy <= (r_state != S_IDLE) || !w_empty;
            if (w_pop) begin
                r_shift <= r_mem[r_rptr[AW-1:0]];
            end else if ((r_state == S_DATA) && w_baud_done) begin
                r_shift <= {1'b0, r_shift[7:1]};
            end
            // A pop always coincides with IDLE or the last STOP cycle, so the counter restarts at 0.
            if ((r_state == S_IDLE) || w_baud_done) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + {{(BW-1){1'b0}}, 1'b1};
            end
            if (r_state == S_START) begin
                r_bit_idx <= 3'd0;
            end else if ((r_state == S_DATA) && w_baud_done) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: a 10 clk/bit instance for the functional scenarios and a
// default-parameter instance for the real 434-cycle bit period.
module tb_uart_tx_fifo;

    localparam int N1 = 10;
    localparam int N2 = 434;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo_if wif1 ();
    uart_tx_fifo_if wif2 ();

    logic       ser1, ser2, busy1, busy2;
    logic [4:0] lvl1, lvl2;

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUDRATE(100_000), .FIFO_DEPTH(16)) dut1 (
        .clk_i(clk), .rst_i(rst), .wr(wif1.slave),
        .ser_tx_o(ser1), .busy_o(busy1), .level_o(lvl1)
    );

    uart_tx_fifo dut2 (
        .clk_i(clk), .rst_i(rst), .wr(wif2.slave),
        .ser_tx_o(ser2), .busy_o(busy2), .level_o(lvl2)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb1[$];
    logic [7:0] sb2[$];
    int         starts1[$];
    int         starts2[$];

    typedef struct {
        int         offs;
        logic       tx;
        logic       busy;
        logic [4:0] level;
    } chk_t;
    chk_t tbl[17];

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic line(input int w);
        return (w == 0) ? ser1 : ser2;
    endfunction

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge e.
    task automatic write1(input int w, input logic [7:0] b, output int e);
        int   guard;
        logic rdy;
        guard = 0;
        if (w == 0) begin
            wif1.wdata_i = b; wif1.wvalid_i = 1'b1; sb1.push_back(b);
            rdy = wif1.wready_o;
        end else begin
            wif2.wdata_i = b; wif2.wvalid_i = 1'b1; sb2.push_back(b);
            rdy = wif2.wready_o;
        end
        while (!rdy && guard < 5000) begin
            @(negedge clk);
            guard++;
            rdy = (w == 0) ? wif1.wready_o : wif2.wready_o;
        end
        if (!rdy) check_eq("write_accept_timeout", rdy, 1'b1);
        @(posedge clk);
        #1;
        e = cyc;
        @(negedge clk);
        if (w == 0) wif1.wvalid_i = 1'b0;
        else        wif2.wvalid_i = 1'b0;
    endtask

    task automatic wait_idle(input int w, input int bound);
        int k;
        k = 0;
        while (k < bound && (((w == 0) ? busy1 : busy2) !== 1'b0 ||
                             ((w == 0) ? sb1.size() : sb2.size()) != 0)) begin
            @(negedge clk);
            k++;
        end
        check_eq("idle_within_bound", (k < bound), 1'b1);
        repeat (3) @(negedge clk);
    endtask

    // Line monitor: every cycle of each frame is compared against the expected
    // start/data/stop pattern; a reset abandons the frame in progress.
    task automatic monitor(input int w, input int n);
        logic [7:0] exp, got;
        logic [9:0] pat;
        int         bad, t0;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (!rst && line(w) === 1'b0) begin
                t0 = cyc; bad = 0; aborted = 1'b0; got = 8'h00; exp = 8'h00;
                check_eq("frame_expected", ((w == 0) ? sb1.size() : sb2.size()) > 0, 1'b1);
                if (w == 0 && sb1.size() > 0) exp = sb1.pop_front();
                if (w == 1 && sb2.size() > 0) exp = sb2.pop_front();
                pat = {1'b1, exp, 1'b0};
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int c = 0; c < n && !aborted; c++) begin
                        if (!(b == 0 && c == 0)) @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                        end else begin
                            if (line(w) !== pat[b]) bad++;
                            if (c == n / 2 && b >= 1 && b <= 8) got[b-1] = line(w);
                        end
                    end
                end
                if (!aborted) begin
                    if (w == 0) starts1.push_back(t0);
                    else        starts2.push_back(t0);
                    check_eq("frame_data", got, exp);
                    check_eq("frame_timing_bad_cycles", bad, 0);
                end
            end
        end
    endtask

    initial monitor(0, N1);
    initial monitor(1, N2);

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int e, c0, E, cnt;
        int es[20];

        // Checkpoints of a single 8'hA5 frame relative to the accepting edge
        tbl[0]  = '{0,   1'b1, 1'b0, 5'd1};
        tbl[1]  = '{1,   1'b1, 1'b1, 5'd0};
        tbl[2]  = '{2,   1'b0, 1'b1, 5'd0};
        tbl[3]  = '{11,  1'b0, 1'b1, 5'd0};
        tbl[4]  = '{12,  1'b1, 1'b1, 5'd0};
        tbl[5]  = '{21,  1'b1, 1'b1, 5'd0};
        tbl[6]  = '{22,  1'b0, 1'b1, 5'd0};
        tbl[7]  = '{32,  1'b1, 1'b1, 5'd0};
        tbl[8]  = '{42,  1'b0, 1'b1, 5'd0};
        tbl[9]  = '{52,  1'b0, 1'b1, 5'd0};
        tbl[10] = '{62,  1'b1, 1'b1, 5'd0};
        tbl[11] = '{72,  1'b0, 1'b1, 5'd0};
        tbl[12] = '{82,  1'b1, 1'b1, 5'd0};
        tbl[13] = '{91,  1'b1, 1'b1, 5'd0};
        tbl[14] = '{92,  1'b1, 1'b1, 5'd0};
        tbl[15] = '{101, 1'b1, 1'b1, 5'd0};
        tbl[16] = '{102, 1'b1, 1'b0, 5'd0};

        wif1.wdata_i = 8'h00; wif1.wvalid_i = 1'b0;
        wif2.wdata_i = 8'h00; wif2.wvalid_i = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_ser1", ser1, 1'b1);
        check_eq("rst_busy1", busy1, 1'b0);
        check_eq("rst_level1", lvl1, 5'd0);
        check_eq("rst_wready1", wif1.wready_o, 1'b1);
        check_eq("rst_ser2", ser2, 1'b1);
        check_eq("rst_busy2", busy2, 1'b0);
        check_eq("rst_level2", lvl2, 5'd0);
        check_eq("rst_wready2", wif2.wready_o, 1'b1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte, table-driven checkpoints
        write1(0, 8'hA5, e);
        for (int i = 0; i < 17; i++) begin
            wait_cyc(e + tbl[i].offs);
            check_eq($sformatf("single_tx_%0d", tbl[i].offs), ser1, tbl[i].tx);
            check_eq($sformatf("single_busy_%0d", tbl[i].offs), busy1, tbl[i].busy);
            check_eq($sformatf("single_level_%0d", tbl[i].offs), lvl1, tbl[i].level);
        end
        wait_idle(0, 500);

        // Burst of three: frames must abut exactly
        starts1.delete();
        write1(0, 8'h48, E);
        write1(0, 8'h69, e);
        check_eq("burst_accept2", e, E + 1);
        write1(0, 8'h0A, e);
        check_eq("burst_accept3", e, E + 2);
        wait_idle(0, 1000);
        check_eq("burst_frames", starts1.size(), 3);
        if (starts1.size() == 3) begin
            check_eq("burst_start0", starts1[0], E + 2);
            check_eq("burst_start1", starts1[1], E + 102);
            check_eq("burst_start2", starts1[2], E + 202);
        end

        // Fill: valid held high over 20 bytes
        starts1.delete();
        c0 = cyc;
        E  = c0 + 1;
        fork
            begin
                for (int i = 0; i < 20; i++) write1(0, 8'h30 + 8'(i), es[i]);
            end
            begin
                wait_cyc(E + 16);
                check_eq("fill_level_full", lvl1, 5'd16);
                check_eq("fill_wready_low", wif1.wready_o, 1'b0);
                wait_cyc(E + 100);
                check_eq("fill_still_full", wif1.wready_o, 1'b0);
                wait_cyc(E + 101);
                check_eq("fill_level_after_pop", lvl1, 5'd15);
                check_eq("fill_wready_after_pop", wif1.wready_o, 1'b1);
            end
        join
        check_eq("fill_acc0", es[0], E);
        check_eq("fill_acc16", es[16], E + 16);
        check_eq("fill_acc17", es[17], E + 102);
        check_eq("fill_acc18", es[18], E + 202);
        check_eq("fill_acc19", es[19], E + 302);
        wait_idle(0, 3000);
        check_eq("fill_frames", starts1.size(), 20);

        // Push coinciding with the STOP-end pop at level 5
        starts1.delete();
        write1(0, 8'hC0, E);
        for (int i = 1; i < 6; i++) write1(0, 8'hC0 + 8'(i), e);
        wait_cyc(E + 100);
        check_eq("simul_level_before", lvl1, 5'd5);
        write1(0, 8'hEE, e);
        check_eq("simul_accept_edge", e, E + 101);
        check_eq("simul_level_after", lvl1, 5'd5);
        wait_idle(0, 1500);
        check_eq("simul_frames", starts1.size(), 7);
        if (starts1.size() > 1) check_eq("simul_next_start", starts1[1], E + 102);

        // Reset during data bit 3 with four bytes queued
        starts1.delete();
        write1(0, 8'hF0, E);
        for (int i = 1; i < 5; i++) write1(0, 8'h10 * 8'(i) + 8'(i), e);
        wait_cyc(E + 45);
        check_eq("rstmid_bit3_low", ser1, 1'b0);
        check_eq("rstmid_level_before", lvl1, 5'd4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rstmid_ser", ser1, 1'b1);
        check_eq("rstmid_level", lvl1, 5'd0);
        check_eq("rstmid_busy", busy1, 1'b0);
        sb1.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (ser1 !== 1'b1 || busy1 !== 1'b0) cnt++;
        end
        check_eq("rstmid_quiet_cycles", cnt, 0);
        check_eq("rstmid_no_frames", starts1.size(), 0);
        write1(0, 8'h5A, e);
        wait_idle(0, 500);
        check_eq("rstmid_resume_frames", starts1.size(), 1);

        // Default parameters: 434-cycle bits
        write1(1, 8'hC3, e);
        wait_idle(1, 6000);
        check_eq("dflt_frames", starts2.size(), 1);
        if (starts2.size() == 1) check_eq("dflt_start", starts2[0], e + 2);
        check_eq("dflt_tx_idle", ser2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
